jtag_dma_cmd_ctrl: RTL and testbench

Command controller directly upstream of the JTAG bus-master DMA. It accepts single-word read/write commands decoded from the JTAG data register and stages write data into the shared 512x32 buffer at address 0. It strobes the DMA's dataReady/readReady request, tracks completion through the DMA's switch-ready handshake, then returns read data plus a status code to the JTAG capture logic.

---
 rtl/jtag_dma_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_jtag_dma_cmd_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_dma_cmd_ctrl.sv
// Single-word JTAG command controller that sits in front of the bus-master DMA.
// The optional auto-increment read opcode is compiled in with JTAG_DMA_AUTOINC_EN.
module jtag_dma_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [8:0]  BUF_SLOT       = 9'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_opcode,
    input  logic [31:0] cmd_address,
    input  logic [3:0]  cmd_byte_enable,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        ipcore_dataReady,
    output logic        ipcore_readReady,
    output logic [3:0]  ipcore_byteEnable,
    output logic [31:0] ipcore_address_to_read,
    input  logic        ipcore_switch_ready,
    input  logic        bus_error,
    output logic [8:0]  buf_address,
    output logic [31:0] buf_dataIn,
    output logic        buf_writeEnable,
    input  logic [31:0] buf_dataOut,
    output logic [2:0]  o_dbg_state
);

    // Handshakes: a command or response transfers on the rising clock edge where valid and
    // ready are both high; the valid side holds its payload stable until that edge.

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_BUF_WRITE  = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_BUF_READ   = 3'd5,
        ST_CAPTURE    = 3'd6,
        ST_RESP       = 3'd7
    } state_t;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_AUTOINC = 2'b11;

    localparam logic [1:0] STS_OK      = 2'd0;
    localparam logic [1:0] STS_BUS_ERR = 2'd1;
    localparam logic [1:0] STS_TIMEOUT = 2'd2;
    localparam logic [1:0] STS_ILLEGAL = 2'd3;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_is_write;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [15:0] r_tmo;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_status;
`ifdef JTAG_DMA_AUTOINC_EN
    logic [31:0] r_last_addr;
    logic [31:0] w_inc_addr;
`endif

    state_t      w_next;
    logic        w_accept;
    logic        w_strobe;
    logic        w_rsp_load;
    logic [1:0]  w_rsp_status;
    logic        w_active;
    logic        w_err;
    logic        w_tmo;
    logic        w_sr;

    assign w_active = (r_state == ST_ISSUE) || (r_state == ST_WAIT_START) ||
                      (r_state == ST_WAIT_DONE);
    // A bus error seen this cycle counts as immediately as one already latched.
    assign w_err    = r_err | bus_error;
    assign w_tmo    = (r_tmo >= TMO_LAST);
    assign w_sr     = ipcore_switch_ready;
`ifdef JTAG_DMA_AUTOINC_EN
    assign w_inc_addr = r_last_addr + 32'd4;
`endif

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_strobe     = 1'b0;
        w_rsp_load   = 1'b0;
        w_rsp_status = STS_OK;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    case (cmd_opcode)
                        OP_WRITE: w_next = ST_BUF_WRITE;
                        OP_READ:  w_next = ST_ISSUE;
                        OP_AUTOINC: begin
`ifdef JTAG_DMA_AUTOINC_EN
                            w_next = ST_ISSUE;
`else
                            w_next       = ST_RESP;
                            w_rsp_load   = 1'b1;
                            w_rsp_status = STS_ILLEGAL;
`endif
                        end
                        default: begin
                            w_next       = ST_RESP;
                            w_rsp_load   = 1'b1;
                            w_rsp_status = STS_OK;
                        end
                    endcase
                end
            end
            ST_BUF_WRITE: w_next = ST_ISSUE;
            ST_ISSUE, ST_WAIT_START, ST_WAIT_DONE: begin
                // Priority: bus error, then timeout, then normal progress.
                if (w_err && w_sr) begin
                    w_next       = ST_RESP;
                    w_rsp_load   = 1'b1;
                    w_rsp_status = STS_BUS_ERR;
                end else if (w_tmo) begin
                    w_next       = ST_RESP;
                    w_rsp_load   = 1'b1;
                    w_rsp_status = w_err ? STS_BUS_ERR : STS_TIMEOUT;
                end else if (r_state == ST_ISSUE) begin
                    if (w_sr) begin
                        w_strobe = 1'b1;
                        w_next   = ST_WAIT_START;
                    end
                end else if (r_state == ST_WAIT_START) begin
                    if (!w_sr) w_next = ST_WAIT_DONE;
                end else if (w_sr) begin
                    if (r_is_write) begin
                        w_next       = ST_RESP;
                        w_rsp_load   = 1'b1;
                        w_rsp_status = STS_OK;
                    end else begin
                        w_next = ST_BUF_READ;
                    end
                end
            end
            ST_BUF_READ: w_next = ST_CAPTURE;
            ST_CAPTURE: begin
                w_next       = ST_RESP;
                w_rsp_load   = 1'b1;
                w_rsp_status = STS_OK;
            end
            ST_RESP: begin
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_tmo        <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
`ifdef JTAG_DMA_AUTOINC_EN
            r_last_addr  <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_write   <= (cmd_opcode == OP_WRITE);
                r_addr       <= cmd_address;
                r_be         <= cmd_byte_enable;
                r_wdata      <= cmd_wdata;
                r_err        <= 1'b0;
                r_rsp_data   <= '0;
                r_rsp_status <= STS_OK;
`ifdef JTAG_DMA_AUTOINC_EN
                if (cmd_opcode == OP_AUTOINC) begin
                    r_addr      <= w_inc_addr;
                    r_last_addr <= w_inc_addr;
                end else if (cmd_opcode != OP_NOP) begin
                    r_last_addr <= cmd_address;
                end
`endif
            end
            if (w_active && bus_error) r_err <= 1'b1;
            // The timeout window restarts every time ISSUE is entered and saturates.
            if ((w_next == ST_ISSUE) && (r_state != ST_ISSUE)) begin
                r_tmo <= '0;
            end else if (w_active && (r_tmo != 16'hFFFF)) begin
                r_tmo <= r_tmo + 16'd1;
            end
            if (w_rsp_load) r_rsp_status <= w_rsp_status;
            if (r_state == ST_CAPTURE) r_rsp_data <= buf_dataOut;
        end
    end

    assign cmd_ready              = (r_state == ST_IDLE) && reset;
    assign rsp_valid              = (r_state == ST_RESP);
    assign rsp_data               = r_rsp_data;
    assign rsp_status             = r_rsp_status;
    assign ipcore_dataReady       = w_strobe && r_is_write;
    assign ipcore_readReady       = w_strobe && !r_is_write;
    assign ipcore_byteEnable      = w_active ? r_be : 4'd0;
    assign ipcore_address_to_read = w_active ? r_addr : 32'd0;
    assign buf_writeEnable        = (r_state == ST_BUF_WRITE);
    assign buf_address            = ((r_state == ST_BUF_WRITE) || (r_state == ST_BUF_READ)) ?
                                    BUF_SLOT : 9'd0;
    assign buf_dataIn             = (r_state == ST_BUF_WRITE) ? r_wdata : 32'd0;
    assign o_dbg_state            = r_state;

endmodule

// File: tb/tb_jtag_dma_cmd_ctrl.sv
// Bench for jtag_dma_cmd_ctrl: DMA + shared-buffer model, scoreboard of expected responses.
module tb_jtag_dma_cmd_ctrl;
  localparam int TMO = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_BUF_READ = 3'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode = 2'b00;
  logic [31:0] cmd_address = '0;
  logic [3:0]  cmd_byte_enable = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        ipcore_dataReady;
  logic        ipcore_readReady;
  logic [3:0]  ipcore_byteEnable;
  logic [31:0] ipcore_address_to_read;
  logic        ipcore_switch_ready = 1'b1;
  logic        bus_error = 1'b0;
  logic [8:0]  buf_address;
  logic [31:0] buf_dataIn;
  logic        buf_writeEnable;
  logic [31:0] buf_dataOut = '0;
  logic [2:0]  o_dbg_state;

  jtag_dma_cmd_ctrl #(.TIMEOUT_CYCLES(TMO), .BUF_SLOT(9'h000)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_address(cmd_address), .cmd_byte_enable(cmd_byte_enable), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .ipcore_dataReady(ipcore_dataReady), .ipcore_readReady(ipcore_readReady),
    .ipcore_byteEnable(ipcore_byteEnable), .ipcore_address_to_read(ipcore_address_to_read),
    .ipcore_switch_ready(ipcore_switch_ready), .bus_error(bus_error),
    .buf_address(buf_address), .buf_dataIn(buf_dataIn), .buf_writeEnable(buf_writeEnable),
    .buf_dataOut(buf_dataOut), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  initial forever #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- DMA + buffer model ----------------
  logic [31:0] buf_mem [512];
  int          dma_mode = 0;   // 0 normal, 1 never drops switch_ready, 2 bus error while busy
  logic [31:0] dma_rdata = '0;
  int          dma_t = 0;
  logic        dma_rd = 1'b0;
  int          n_dr = 0, n_rr = 0, n_bw = 0, n_brd = 0;
  int          dr_cyc = 0, rr_cyc = 0, bw_cyc = 0;
  logic [31:0] dr_addr = '0, rr_addr = '0, bw_data = '0, dr_mem0 = '0, held_addr = '0;
  logic [3:0]  dr_be = '0, rr_be = '0, held_be = '0;
  logic [8:0]  bw_addr = '0;

  initial begin
    for (int i = 0; i < 512; i++) buf_mem[i] = '0;
    forever begin
      @(negedge clock);
      if (buf_writeEnable) begin
        buf_mem[buf_address] = buf_dataIn;
        n_bw++; bw_cyc = cyc; bw_addr = buf_address; bw_data = buf_dataIn;
      end
      if (o_dbg_state == S_BUF_READ) n_brd++;
      if (ipcore_dataReady) begin
        n_dr++; dr_cyc = cyc; dr_addr = ipcore_address_to_read; dr_be = ipcore_byteEnable;
        dr_mem0 = buf_mem[0];
      end
      if (ipcore_readReady) begin
        n_rr++; rr_cyc = cyc; rr_addr = ipcore_address_to_read; rr_be = ipcore_byteEnable;
      end
      if ((ipcore_dataReady || ipcore_readReady) && dma_mode != 1) begin
        dma_t = 1;
        dma_rd = ipcore_readReady;
      end else if (dma_t > 0) begin
        dma_t++;
        case (dma_t)
          2: ipcore_switch_ready = 1'b0;
          3: begin
            held_addr = ipcore_address_to_read;
            held_be = ipcore_byteEnable;
            if (dma_rd) buf_mem[0] = dma_rdata;
            if (dma_mode == 2) bus_error = 1'b1;
          end
          4: bus_error = 1'b0;
          default: begin
            ipcore_switch_ready = 1'b1;
            dma_t = 0;
          end
        endcase
      end
      buf_dataOut = buf_mem[buf_address];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic push, input logic [33:0] exp);
    int t = 0;
    cmd_opcode = op; cmd_address = addr; cmd_byte_enable = be; cmd_wdata = wd;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept: cmd_ready=%b required=1 within 100 cycles", cmd_ready);
    end else if (push) begin
      exp_q.push_back(exp);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [33:0] got, output logic [33:0] exp, output int at_cyc);
    int t = 0;
    while (!rsp_valid && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!rsp_valid) begin
      n_cmp++; n_err++;
      $display("FAIL rsp_wait: rsp_valid=%b required=1 within 300 cycles", rsp_valid);
    end
    got = {rsp_status, rsp_data};
    at_cyc = cyc;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 'x;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [115:0] all_outs();
    return {cmd_ready, rsp_valid, rsp_data, rsp_status, ipcore_dataReady, ipcore_readReady,
            ipcore_byteEnable, ipcore_address_to_read, buf_address, buf_dataIn, buf_writeEnable};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_outs: got=%h required=0", all_outs());
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || o_dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b state=%0d required 1/0/0",
               cmd_ready, rsp_valid, o_dbg_state);
    end
    @(negedge clock);
  endtask

  task automatic test_autoinc_fresh();
    logic [33:0] got, exp;
    int at, rr0;
    rr0 = n_rr;
    dma_rdata = 32'hA5A50004;
`ifdef JTAG_DMA_AUTOINC_EN
    send_cmd(2'b11, 32'h55555550, 4'hF, 32'h0, 1'b1, {2'd0, 32'hA5A50004});
`else
    send_cmd(2'b11, 32'h55555550, 4'hF, 32'h0, 1'b1, {2'd3, 32'h0});
`endif
    wait_rsp(got, exp, at);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL autoinc_fresh_rsp: got=%h required=%h", got, exp);
    end
`ifdef JTAG_DMA_AUTOINC_EN
    n_cmp++;
    if (rr_addr !== 32'h4 || n_rr - rr0 != 1) begin
      n_err++; $display("FAIL autoinc_fresh_addr: got=%h pulses=%0d required=00000004 pulses=1",
                        rr_addr, n_rr - rr0);
    end
`else
    n_cmp++;
    if (n_rr != rr0) begin
      n_err++; $display("FAIL autoinc_off_strobe: pulses=%0d required=0", n_rr - rr0);
    end
`endif
    release_rsp();
  endtask

  task automatic test_write();
    logic [33:0] got, exp, first;
    int at, dr0;
    dr0 = n_dr;
    send_cmd(2'b01, 32'h40000010, 4'hF, 32'hDEADBEEF, 1'b1, {2'd0, 32'h0});
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL write_busy_ready: cmd_ready=%b required=0", cmd_ready);
    end
    wait_rsp(got, exp, at);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL write_rsp: got=%h required=%h", got, exp);
    end
    n_cmp++;
    if (n_dr - dr0 != 1) begin
      n_err++; $display("FAIL write_pulses: got=%0d required=1", n_dr - dr0);
    end
    n_cmp++;
    if (bw_data !== 32'hDEADBEEF || bw_addr !== 9'h000 || bw_cyc != dr_cyc - 1 ||
        dr_mem0 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_buffer: data=%h addr=%h wcyc=%0d strobe_cyc=%0d slot0=%h required DEADBEEF/000/strobe-1/DEADBEEF",
               bw_data, bw_addr, bw_cyc, dr_cyc, dr_mem0);
    end
    n_cmp++;
    if (dr_addr !== 32'h40000010 || dr_be !== 4'hF || held_addr !== 32'h40000010 ||
        held_be !== 4'hF) begin
      n_err++;
      $display("FAIL write_addr_be: strobe=%h/%h busy=%h/%h required 40000010/f",
               dr_addr, dr_be, held_addr, held_be);
    end
    first = got;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if (rsp_valid !== 1'b1 || {rsp_status, rsp_data} !== first) begin
        n_err++;
        $display("FAIL rsp_hold: valid=%b rsp=%h required 1/%h", rsp_valid,
                 {rsp_status, rsp_data}, first);
      end
    end
    release_rsp();
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL rsp_release: valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read(input logic [31:0] addr, input logic [31:0] rdata);
    logic [33:0] got, exp;
    int at, rr0, brd0;
    rr0 = n_rr; brd0 = n_brd;
    dma_rdata = rdata;
    send_cmd(2'b10, addr, 4'h3, 32'h0, 1'b1, {2'd0, rdata});
    wait_rsp(got, exp, at);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL read_rsp: got=%h required=%h", got, exp);
    end
    n_cmp++;
    if (n_rr - rr0 != 1 || rr_addr !== addr || rr_be !== 4'h3 || held_addr !== addr ||
        n_brd - brd0 != 1) begin
      n_err++;
      $display("FAIL read_strobe: pulses=%0d addr=%h be=%h busy_addr=%h bufrd=%0d required 1/%h/3/%h/1",
               n_rr - rr0, rr_addr, rr_be, held_addr, n_brd - brd0, addr, addr);
    end
    release_rsp();
  endtask

  task automatic test_read_bus_error();
    logic [33:0] got, exp;
    int at, rr0, brd0;
    rr0 = n_rr; brd0 = n_brd;
    dma_mode = 2;
    dma_rdata = 32'hCAFEF00D;
    send_cmd(2'b10, 32'h40000030, 4'hF, 32'h0, 1'b1, {2'd1, 32'h0});
    wait_rsp(got, exp, at);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL bus_error_rsp: got=%h required=%h", got, exp);
    end
    n_cmp++;
    if (n_brd != brd0 || n_rr - rr0 != 1) begin
      n_err++; $display("FAIL bus_error_path: bufrd=%0d pulses=%0d required 0/1",
                        n_brd - brd0, n_rr - rr0);
    end
    release_rsp();
    dma_mode = 0;
  endtask

  task automatic test_nop();
    logic [33:0] got, exp;
    int at, s0;
    s0 = n_rr + n_dr;
    send_cmd(2'b00, 32'h12340000, 4'hF, 32'h11111111, 1'b1, {2'd0, 32'h0});
    wait_rsp(got, exp, at);
    n_cmp++;
    if (got !== exp || n_rr + n_dr != s0) begin
      n_err++; $display("FAIL nop_rsp: got=%h strobes=%0d required=%h strobes=0",
                        got, n_rr + n_dr - s0, exp);
    end
    release_rsp();
  endtask

  task automatic test_timeout();
    logic [33:0] got, exp;
    int at, rr0;
    rr0 = n_rr;
    dma_mode = 1;
    send_cmd(2'b10, 32'h40000040, 4'hF, 32'h0, 1'b1, {2'd2, 32'h0});
    wait_rsp(got, exp, at);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL timeout_rsp: got=%h required=%h", got, exp);
    end
    n_cmp++;
    if (at - rr_cyc != TMO || n_rr - rr0 != 1) begin
      n_err++; $display("FAIL timeout_latency: cycles=%0d pulses=%0d required %0d/1",
                        at - rr_cyc, n_rr - rr0, TMO);
    end
    release_rsp();
    dma_mode = 0;
  endtask

  task automatic test_autoinc_wrap();
    logic [33:0] got, exp;
    int at, rr0;
    test_read(32'hFFFFFFFC, 32'h0BADCAFE);
    rr0 = n_rr;
    dma_rdata = 32'h600DF00D;
`ifdef JTAG_DMA_AUTOINC_EN
    send_cmd(2'b11, 32'h77777770, 4'hF, 32'h0, 1'b1, {2'd0, 32'h600DF00D});
`else
    send_cmd(2'b11, 32'h77777770, 4'hF, 32'h0, 1'b1, {2'd3, 32'h0});
`endif
    wait_rsp(got, exp, at);
    n_cmp++;
    if (got !== exp) begin
      n_err++; $display("FAIL autoinc_wrap_rsp: got=%h required=%h", got, exp);
    end
`ifdef JTAG_DMA_AUTOINC_EN
    n_cmp++;
    if (rr_addr !== 32'h0 || n_rr - rr0 != 1) begin
      n_err++; $display("FAIL autoinc_wrap_addr: got=%h pulses=%0d required=00000000/1",
                        rr_addr, n_rr - rr0);
    end
`else
    n_cmp++;
    if (n_rr != rr0) begin
      n_err++; $display("FAIL autoinc_wrap_strobe: pulses=%0d required=0", n_rr - rr0);
    end
`endif
    release_rsp();
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int s0;
    dma_rdata = 32'h99999999;
    send_cmd(2'b10, 32'h40000050, 4'hF, 32'h0, 1'b0, '0);
    while (o_dbg_state !== S_WAIT_DONE && t < 50) begin
      @(negedge clock);
      t++;
    end
    n_cmp++;
    if (o_dbg_state !== S_WAIT_DONE) begin
      n_err++; $display("FAIL reset_mid_reach: state=%0d required=%0d", o_dbg_state, S_WAIT_DONE);
    end
    s0 = n_rr + n_dr;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_err++; $display("FAIL reset_mid_outs: got=%h required=0", all_outs());
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_ready: cmd_ready=%b required=1", cmd_ready);
    end
    repeat (10) @(negedge clock);
    n_cmp++;
    if (n_rr + n_dr != s0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_quiet: strobes=%0d rsp_valid=%b required 0/0",
                        n_rr + n_dr - s0, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] got, exp;
    logic [31:0] a, d;
    int at;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        send_cmd(2'b01, a, 4'(i + 1), d, 1'b1, {2'd0, 32'h0});
      end else begin
        dma_rdata = d;
        send_cmd(2'b10, a, 4'(i + 1), 32'h0, 1'b1, {2'd0, d});
      end
      wait_rsp(got, exp, at);
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL b2b_rsp[%0d]: got=%h required=%h", i, got, exp);
      end
      release_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_autoinc_fresh();
    test_write();
    test_read(32'h40000020, 32'h12345678);
    test_read_bus_error();
    test_nop();
    test_timeout();
    test_autoinc_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
